// File: rtl/mcs_di_pkg.sv
// Shared definitions for the MCS-to-DI bridge.
//   state_e     : bridge FSM states
//   ERR_STATUS  : status returned for an unsupported byte-enable pattern
//   TMO_STATUS  : status returned when a transaction times out
//   be_to_len() : MCS byte enable -> DI byte count (0 marks an illegal pattern)
package mcs_di_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WR_ACK  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_CAP  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [15:0] ERR_STATUS = 16'hFFFE;
    localparam logic [15:0] TMO_STATUS = 16'hFFFF;

    // Only contiguous low-aligned lane groups of 4, 2 or 1 bytes are legal.
    function automatic logic [2:0] be_to_len(input logic [3:0] be);
        logic [2:0] len;
        case (be)
            4'hF:    len = 3'd4;
            4'h3:    len = 3'd2;
            4'h1:    len = 3'd1;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcs_di_beat_packer.sv
// Beat-indexed pack/unpack mux between the 32-bit MCS word and DI beats.
//   beat_i    : current beat index (LSB beat is 0)
//   wdata_i   : latched 32-bit write word
//   rbuf_i    : read word assembled so far
//   rd_beat_i : DI read beat to merge into rbuf_i
//   wr_beat_o : write word slice for the current beat
//   rbuf_o    : rbuf_i with rd_beat_i placed into the current beat slice
module mcs_di_beat_packer
    import mcs_di_pkg::*;
#(
    parameter int DI_DATA_WIDTH = 32,
    parameter int BEATS_MAX     = 32 / DI_DATA_WIDTH
) (
    input  logic [1:0]               beat_i,
    input  logic [31:0]              wdata_i,
    input  logic [31:0]              rbuf_i,
    input  logic [DI_DATA_WIDTH-1:0] rd_beat_i,
    output logic [DI_DATA_WIDTH-1:0] wr_beat_o,
    output logic [31:0]              rbuf_o
);

    // AND-OR select of the write slice and in-place insert of the read slice.
    always_comb begin
        wr_beat_o = '0;
        rbuf_o    = rbuf_i;
        for (int b = 0; b < BEATS_MAX; b++) begin
            wr_beat_o = wr_beat_o |
                        ({DI_DATA_WIDTH{beat_i == b[1:0]}} & wdata_i[b*DI_DATA_WIDTH +: DI_DATA_WIDTH]);
            rbuf_o[b*DI_DATA_WIDTH +: DI_DATA_WIDTH] = (beat_i == b[1:0]) ? rd_beat_i
                                                     : rbuf_i[b*DI_DATA_WIDTH +: DI_DATA_WIDTH];
        end
    end

endmodule

// File: rtl/mcs_di_bridge.sv
// Bridge from the MicroBlaze MCS IO bus to the DI terminal bus. Each 32-bit
// MCS access is split into 1, 2 or 4 DI beats of DI_DATA_WIDTH bits.
//   MCS side : IO_*_Strobe, IO_Address, IO_Byte_Enable, IO_Write_Data in;
//              IO_Read_Data, IO_Ready (1-cycle completion pulse) out
//   Control  : mcs_term_addr in; mcs_transfer_status, busy out
//   DI side  : di_term_addr, di_reg_addr, di_len, di_read_mode/req/read,
//              di_write_mode/write, di_reg_datai out; di_read_rdy,
//              di_write_rdy, di_reg_datao, di_timeout_count,
//              di_transfer_status in
module mcs_di_bridge #(
    parameter int          DI_DATA_WIDTH = 32,
    parameter int          BEATS_MAX     = 32 / DI_DATA_WIDTH,
    parameter logic [15:0] ERR_STATUS    = mcs_di_pkg::ERR_STATUS,
    parameter logic [15:0] TMO_STATUS    = mcs_di_pkg::TMO_STATUS
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    input  logic                     IO_Addr_Strobe,
    input  logic                     IO_Read_Strobe,
    input  logic                     IO_Write_Strobe,
    input  logic [31:0]              IO_Address,
    input  logic [3:0]               IO_Byte_Enable,
    input  logic [31:0]              IO_Write_Data,
    output logic [31:0]              IO_Read_Data,
    output logic                     IO_Ready,
    input  logic [15:0]              mcs_term_addr,
    output logic [15:0]              mcs_transfer_status,
    output logic [15:0]              di_term_addr,
    output logic [31:0]              di_reg_addr,
    output logic [31:0]              di_len,
    output logic                     di_read_mode,
    output logic                     di_read_req,
    output logic                     di_read,
    input  logic                     di_read_rdy,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    input  logic [31:0]              di_timeout_count,
    output logic                     di_write,
    input  logic                     di_write_rdy,
    output logic                     di_write_mode,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    input  logic [15:0]              di_transfer_status,
    output logic                     busy
);

    import mcs_di_pkg::*;

    state_e      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] tmo_q, tmo_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] status_q, status_d;
    logic [15:0] term_q;
    logic        rd_mode_q, rd_mode_d;
    logic        wr_mode_q, wr_mode_d;
    logic        rd_req_q, rd_req_d;
    logic        rd_pulse_q, rd_pulse_d;
    logic        wr_pulse_q, wr_pulse_d;

    logic [2:0]               len_s;
    logic [1:0]               last_beat_s;
    int                       nb_s;
    logic                     tmo_hit_s;
    logic [DI_DATA_WIDTH-1:0] wr_beat_s;
    logic [31:0]              rbuf_ins_s;
    logic                     unused_s;

    assign unused_s = ^{IO_Addr_Strobe, IO_Address[31:30], IO_Address[1:0]};
    assign len_s    = be_to_len(IO_Byte_Enable);

    // Counter already includes the strobe cycle; 33-bit compare avoids wrap.
    assign tmo_hit_s = (di_timeout_count != 32'd0) &&
                       (({1'b0, tmo_q} + 33'd1) >= {1'b0, di_timeout_count});

    // Index of the final beat: ceil(bytes*8/width) - 1, never below 0.
    always_comb begin
        nb_s        = (int'(len_q) * 32'sd8 + DI_DATA_WIDTH - 32'sd1) / DI_DATA_WIDTH;
        last_beat_s = (nb_s > 32'sd1) ? 2'(nb_s - 32'sd1) : 2'd0;
    end

    mcs_di_beat_packer #(
        .DI_DATA_WIDTH (DI_DATA_WIDTH),
        .BEATS_MAX     (BEATS_MAX)
    ) u_packer (
        .beat_i    (beat_q),
        .wdata_i   (wdata_q),
        .rbuf_i    (rbuf_q),
        .rd_beat_i (di_reg_datao),
        .wr_beat_o (wr_beat_s),
        .rbuf_o    (rbuf_ins_s)
    );

    // Next-state, beat sequencing, timeout and status selection.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q + 32'd1;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        rd_mode_d  = rd_mode_q;
        wr_mode_d  = wr_mode_q;
        rd_req_d   = 1'b0;
        rd_pulse_d = 1'b0;
        wr_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = 32'd0;
                if (IO_Write_Strobe || IO_Read_Strobe) begin
                    addr_d = {4'b0000, IO_Address[29:2]};
                    len_d  = len_s;
                    beat_d = 2'd0;
                    if (len_s == 3'd0) begin
                        status_d = ERR_STATUS;
                        state_d  = ST_DONE;
                    end else if (IO_Write_Strobe) begin
                        wdata_d   = IO_Write_Data;
                        wr_mode_d = 1'b1;
                        tmo_d     = 32'd1;
                        state_d   = ST_WR_WAIT;
                    end else begin
                        rbuf_d    = 32'd0;
                        rd_mode_d = 1'b1;
                        rd_req_d  = 1'b1;
                        tmo_d     = 32'd1;
                        state_d   = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (tmo_hit_s) begin
                    status_d  = TMO_STATUS;
                    wr_mode_d = 1'b0;
                    rd_mode_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (di_write_rdy) begin
                    wr_pulse_d = 1'b1;
                    state_d    = ST_WR_ACK;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_ACK: begin
                // The cycle carrying di_write itself never counts as the ack.
                if (tmo_hit_s) begin
                    status_d  = TMO_STATUS;
                    wr_mode_d = 1'b0;
                    rd_mode_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (!wr_pulse_q && di_write_rdy) begin
                    if (beat_q == last_beat_s) begin
                        status_d  = di_transfer_status;
                        wr_mode_d = 1'b0;
                        rd_mode_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ST_WR_WAIT;
                    end
                end else begin
                    state_d = ST_WR_ACK;
                end
            end
            ST_RD_WAIT: begin
                if (tmo_hit_s) begin
                    status_d  = TMO_STATUS;
                    wr_mode_d = 1'b0;
                    rd_mode_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (di_read_rdy) begin
                    rd_pulse_d = 1'b1;
                    state_d    = ST_RD_CAP;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_CAP: begin
                // Beat data is valid the cycle after the di_read pulse.
                if (tmo_hit_s) begin
                    status_d  = TMO_STATUS;
                    wr_mode_d = 1'b0;
                    rd_mode_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (!rd_pulse_q) begin
                    rbuf_d = rbuf_ins_s;
                    if (beat_q == last_beat_s) begin
                        rdata_d   = rbuf_ins_s;
                        status_d  = di_transfer_status;
                        wr_mode_d = 1'b0;
                        rd_mode_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_RD_CAP;
                end
            end
            ST_DONE: begin
                tmo_d     = 32'd0;
                wr_mode_d = 1'b0;
                rd_mode_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                tmo_d     = 32'd0;
                wr_mode_d = 1'b0;
                rd_mode_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            beat_q     <= 2'd0;
            tmo_q      <= 32'd0;
            len_q      <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            rdata_q    <= 32'd0;
            status_q   <= 16'd0;
            term_q     <= 16'd0;
            rd_mode_q  <= 1'b0;
            wr_mode_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_pulse_q <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            term_q     <= mcs_term_addr;
            rd_mode_q  <= rd_mode_d;
            wr_mode_q  <= wr_mode_d;
            rd_req_q   <= rd_req_d;
            rd_pulse_q <= rd_pulse_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign IO_Read_Data        = rdata_q;
    assign IO_Ready            = (state_q == ST_DONE);
    assign mcs_transfer_status = status_q;
    assign di_term_addr        = term_q;
    assign di_reg_addr         = addr_q;
    assign di_len              = {29'd0, len_q};
    assign di_read_mode        = rd_mode_q;
    assign di_read_req         = rd_req_q;
    assign di_read             = rd_pulse_q;
    assign di_write            = wr_pulse_q;
    assign di_write_mode       = wr_mode_q;
    assign di_reg_datai        = wr_beat_s;
    assign busy                = (state_q != ST_IDLE);

endmodule
